// File: rtl/write_merge_buffer.sv
// write_merge_buffer: coalesces word stores into line entries and drains them in FIFO order as masked line writes
// Ports: st_* store port (valid/ready), fl_* line-write port (valid/ready), flush_req_i/idle_o drain control,
// ld_* combinational forwarding lookup. Define WMB_LOAD_FORWARD_EN to enable forwarding; otherwise ld_* read 0.
module write_merge_buffer #(
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int OFS_W = $clog2(LINE_BYTES),
  localparam int TAG_W = ADDR_WIDTH - OFS_W
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [ADDR_WIDTH-1:0]   st_addr_i,
  input  logic [8*WORD_BYTES-1:0] st_wdata_i,
  input  logic [WORD_BYTES-1:0]   st_be_i,
  output logic                    fl_valid_o,
  input  logic                    fl_ready_i,
  output logic [TAG_W-1:0]        fl_tag_o,
  output logic [8*LINE_BYTES-1:0] fl_data_o,
  output logic [LINE_BYTES-1:0]   fl_mask_o,
  input  logic                    flush_req_i,
  output logic                    idle_o,
  input  logic [ADDR_WIDTH-1:0]   ld_addr_i,
  output logic                    ld_hit_o,
  output logic [8*WORD_BYTES-1:0] ld_data_o,
  output logic [WORD_BYTES-1:0]   ld_mask_o
);
  localparam int BS_W = $clog2(WORD_BYTES);
  localparam int WO_W = OFS_W - BS_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LB8 = 8 * LINE_BYTES;
  localparam int WB8 = 8 * WORD_BYTES;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [LB8-1:0] data_q [DEPTH];
  logic [LINE_BYTES-1:0] mask_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, slot, ws;
  logic [CNT_W-1:0] count_q, count_d;
  logic lock_q, lock_d, flush_q, flush_d;
  logic hit, acc, alloc, pop;
  logic [TAG_W-1:0] st_tag;
  logic [WO_W-1:0] st_wofs;
  logic [LINE_BYTES-1:0] pmask, wmask, hmask;
  logic [LB8-1:0] pdata, bmask, wdata;
  logic unused_ok;
  assign unused_ok = ^{st_addr_i, ld_addr_i};
  assign st_tag = st_addr_i[ADDR_WIDTH-1:OFS_W];
  assign st_wofs = st_addr_i[OFS_W-1:BS_W];
  always_comb begin
    pmask = LINE_BYTES'(st_be_i) << (st_wofs * WORD_BYTES);
    pdata = LB8'(st_wdata_i) << (st_wofs * WB8);
    bmask = '0;
    for (int b = 0; b < LINE_BYTES; b++) bmask[8*b +: 8] = {8{pmask[b]}};
    // A locked head is frozen for the downstream, so a store to its line must open a new entry.
    hit = count_q != '0 && st_tag == tag_q[tail_q] && !(lock_q && count_q == CNT_W'(1));
    st_ready_o = !flush_q && (hit || count_q < CNT_W'(DEPTH));
    acc = st_valid_i && st_ready_o;
    alloc = acc && !hit;
    pop = lock_q && fl_ready_i;
    slot = count_q == '0 ? head_q : tail_q + 1'b1;
    ws = alloc ? slot : tail_q;
    wmask = alloc ? pmask : mask_q[tail_q] | pmask;
    wdata = alloc ? pdata & bmask : (data_q[tail_q] & ~bmask) | (pdata & bmask);
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = alloc ? slot : tail_q;
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
    flush_d = (flush_q || flush_req_i) && count_d != '0;
    hmask = acc && ws == head_d ? wmask : mask_q[head_d];
    // Presenting and locking are the same event; the condition only grows until the pop.
    lock_d = count_d != '0 && (count_d >= CNT_W'(2) || &hmask || flush_d);
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      lock_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      lock_q <= lock_d;
      flush_q <= flush_d;
      if (acc) begin
        tag_q[ws] <= st_tag;
        data_q[ws] <= wdata;
        mask_q[ws] <= wmask;
      end
    end
  assign fl_valid_o = lock_q;
  assign fl_tag_o = lock_q ? tag_q[head_q] : '0;
  assign fl_data_o = lock_q ? data_q[head_q] : '0;
  assign fl_mask_o = lock_q ? mask_q[head_q] : '0;
  assign idle_o = count_q == '0 && !flush_q;
`ifdef WMB_LOAD_FORWARD_EN
  logic [PTR_W-1:0] idx;
  logic [WORD_BYTES-1:0] em;
  logic [WB8-1:0] ed;
  // Walk oldest to youngest so the youngest matching byte wins.
  always_comb begin
    ld_data_o = '0;
    ld_mask_o = '0;
    idx = '0;
    em = '0;
    ed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      em = WORD_BYTES'(mask_q[idx] >> (ld_addr_i[OFS_W-1:BS_W] * WORD_BYTES));
      ed = WB8'(data_q[idx] >> (ld_addr_i[OFS_W-1:BS_W] * WB8));
      if (CNT_W'(i) < count_q && tag_q[idx] == ld_addr_i[ADDR_WIDTH-1:OFS_W])
        for (int k = 0; k < WORD_BYTES; k++)
          if (em[k]) begin
            ld_mask_o[k] = 1'b1;
            ld_data_o[8*k +: 8] = ed[8*k +: 8];
          end
    end
  end
  assign ld_hit_o = |ld_mask_o;
`else
  assign ld_hit_o = 1'b0;
  assign ld_data_o = '0;
  assign ld_mask_o = '0;
`endif
endmodule

// File: tb/tb_write_merge_buffer.sv
// tb_write_merge_buffer: directed stimulus with a queue-based reference model checked every cycle
module tb_write_merge_buffer;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic st_valid = 1'b0, fl_ready = 1'b0, flush_req = 1'b0;
  logic [15:0] st_addr = '0, ld_addr = '0, st_wdata = '0;
  logic [1:0] st_be = '0;
  logic st_ready, fl_valid, idle, ld_hit;
  logic [11:0] fl_tag;
  logic [127:0] fl_data;
  logic [15:0] fl_mask, ld_data;
  logic [1:0] ld_mask;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  write_merge_buffer dut (
    .clk_i(clk), .reset_i(rst), .st_valid_i(st_valid), .st_ready_o(st_ready),
    .st_addr_i(st_addr), .st_wdata_i(st_wdata), .st_be_i(st_be),
    .fl_valid_o(fl_valid), .fl_ready_i(fl_ready), .fl_tag_o(fl_tag), .fl_data_o(fl_data),
    .fl_mask_o(fl_mask), .flush_req_i(flush_req), .idle_o(idle),
    .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .ld_data_o(ld_data), .ld_mask_o(ld_mask));

  typedef struct packed {
    logic [11:0] tag;
    logic [127:0] data;
    logic [15:0] mask;
  } ent_t;
  ent_t q[$];
  bit m_lock = 0, m_flush = 0;
  logic [11:0] popped[$];

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_hit();
    return q.size() > 0 && q[q.size()-1].tag == st_addr[15:4] && !(m_lock && q.size() == 1);
  endfunction

  function automatic bit m_ready();
    return !m_flush && (m_hit() || q.size() < D);
  endfunction

  function automatic logic [17:0] fwd(input logic [15:0] a);
    logic [1:0] m = '0;
    logic [15:0] d = '0;
    int o = int'(a[3:1]) * 2;
    foreach (q[i])
      if (q[i].tag == a[15:4])
        for (int k = 0; k < 2; k++)
          if (q[i].mask[o+k]) begin
            m[k] = 1'b1;
            d[8*k +: 8] = q[i].data[8*(o+k) +: 8];
          end
    return {m, d};
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      m_lock = 0;
      m_flush = 0;
    end else begin
      bit hit, acc;
      ent_t e;
      int o;
      hit = m_hit();
      acc = st_valid && m_ready();
      if (m_lock && fl_ready) void'(q.pop_front());
      if (acc) begin
        o = int'(st_addr[3:1]) * 2;
        if (hit) e = q[q.size()-1];
        else begin
          e = '0;
          e.tag = st_addr[15:4];
        end
        for (int k = 0; k < 2; k++)
          if (st_be[k]) begin
            e.mask[o+k] = 1'b1;
            e.data[8*(o+k) +: 8] = st_wdata[8*k +: 8];
          end
        if (hit) q[q.size()-1] = e;
        else q.push_back(e);
      end
      m_flush = (m_flush || flush_req) && q.size() != 0;
      m_lock = q.size() != 0 && (q.size() >= 2 || q[0].mask == 16'hFFFF || m_flush);
    end

  always @(negedge clk) begin
    logic [17:0] f;
    chk("fl_valid", fl_valid, m_lock);
    chk("st_ready", st_ready, m_ready());
    chk("idle", idle, q.size() == 0 && !m_flush);
    if (m_lock) begin
      chk("fl_tag", fl_tag, q[0].tag);
      chk("fl_mask", fl_mask, q[0].mask);
      chk("fl_data", fl_data, q[0].data);
    end
`ifdef WMB_LOAD_FORWARD_EN
    f = fwd(ld_addr);
`else
    f = '0;
`endif
    chk("ld_mask", ld_mask, f[17:16]);
    chk("ld_data", ld_data, f[15:0]);
    chk("ld_hit", ld_hit, |f[17:16]);
    if (fl_valid && fl_ready) popped.push_back(fl_tag);
  end

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    int n = 0;
    st_valid = 1'b1;
    st_addr = a;
    st_wdata = d;
    st_be = be;
    ld_addr = a;
    @(negedge clk);
    while (!st_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("store_timeout", n, 0);
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk);
    #1 flush_req = 1'b1;
    fl_ready = 1'b1;
    @(posedge clk);
    #1 flush_req = 1'b0;
    @(negedge clk);
    while (!idle && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("drain_timeout", n, 0);
    fl_ready = 1'b0;
  endtask

  task automatic flush_check(input string n, input logic [11:0] t, input logic [15:0] m, input logic [127:0] d);
    @(posedge clk);
    #1 flush_req = 1'b1;
    @(posedge clk);
    #1 flush_req = 1'b0;
    @(negedge clk);
    chk({n, "_valid"}, fl_valid, 1'b1);
    chk({n, "_tag"}, fl_tag, t);
    chk({n, "_mask"}, fl_mask, m);
    chk({n, "_data"}, fl_data, d);
    fl_ready = 1'b1;
    @(posedge clk);
    #1 fl_ready = 1'b0;
    @(negedge clk);
    chk({n, "_idle"}, idle, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_fl_valid", fl_valid, 1'b0);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_fl_data", fl_data, 128'h0);
    chk("rst_ld_hit", ld_hit, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    // coalesce into one partial line, then flush it out
    store(16'h1000, 16'hBEEF, 2'b11);
    store(16'h1002, 16'h1234, 2'b01);
    ld_addr = 16'h1002;
    repeat (2) @(negedge clk);
    chk("coal_no_drain", fl_valid, 1'b0);
`ifdef WMB_LOAD_FORWARD_EN
    chk("fwd_hit", ld_hit, 1'b1);
    chk("fwd_mask", ld_mask, 2'b01);
    chk("fwd_byte", ld_data[7:0], 8'h34);
`else
    chk("fwd_off_hit", ld_hit, 1'b0);
`endif
    flush_check("coal", 12'h100, 16'h0007, 128'h34BEEF);
    // full line drains without flush
    for (int i = 0; i < 8; i++) store(16'h2000 + 16'(2 * i), 16'h0101 * 16'(i + 1), 2'b11);
    @(negedge clk);
    chk("full_valid", fl_valid, 1'b1);
    chk("full_mask", fl_mask, 16'hFFFF);
    fl_ready = 1'b1;
    @(posedge clk);
    #1 fl_ready = 1'b0;
    @(negedge clk);
    chk("full_idle", idle, 1'b1);
    // line change presents the older entry
    store(16'h3000, 16'hAAAA, 2'b11);
    store(16'h3010, 16'h5555, 2'b11);
    @(negedge clk);
    chk("lc_valid", fl_valid, 1'b1);
    chk("lc_tag", fl_tag, 12'h300);
    chk("lc_mask", fl_mask, 16'h0003);
    drain();
    // full buffer under backpressure
    popped.delete();
    for (int i = 0; i < 4; i++) store(16'h4000 + 16'(16 * i), 16'hC000 + 16'(i), 2'b11);
    st_valid = 1'b1;
    st_addr = 16'h4040;
    st_be = 2'b11;
    @(negedge clk);
    chk("bp_full_miss", st_ready, 1'b0);
    @(posedge clk);
    #1 st_addr = 16'h4032;
    st_wdata = 16'h7777;
    @(negedge clk);
    chk("bp_full_hit", st_ready, 1'b1);
    @(posedge clk);
    #1 st_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_stable_tag", fl_tag, 12'h400);
    end
    drain();
    chk("bp_pop_count", popped.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk("bp_order", popped[i], 12'h400 + 12'(i));
    // reset while a head is presented
    store(16'h5000, 16'h0001, 2'b11);
    store(16'h5010, 16'h0002, 2'b11);
    store(16'h5020, 16'h0003, 2'b11);
    @(negedge clk);
    chk("rm_valid", fl_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rm_fl_valid", fl_valid, 1'b0);
    chk("rm_idle", idle, 1'b1);
    chk("rm_st_ready", st_ready, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    fl_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rm_no_pop", fl_valid, 1'b0);
    end
    fl_ready = 1'b0;
    // empty byte-enable still allocates and drains
    store(16'h6000, 16'hFFFF, 2'b00);
    flush_check("be0", 12'h600, 16'h0000, 128'h0);
    // later store overwrites only its enabled bytes
    store(16'h7004, 16'h1111, 2'b11);
    store(16'h7004, 16'h2222, 2'b10);
    flush_check("ovw", 12'h700, 16'h0030, 128'h2211_0000_0000);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
